// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and constants for the 00.00 stopwatch datapath.
//   bcd_time_t     : four packed BCD digits {d3,d2,d1,d0} (10 s .. 0.01 s)
//   lap_state_t    : display source of the lap recorder (LIVE / RECALL)
//   LAP_DEPTH_DFLT : default number of lap slots
// -----------------------------------------------------------------------------
package stopwatch_pkg;

   typedef struct packed {
      logic [3:0] d3;
      logic [3:0] d2;
      logic [3:0] d1;
      logic [3:0] d0;
   } bcd_time_t;

   typedef enum logic {
      LIVE   = 1'b0,
      RECALL = 1'b1
   } lap_state_t;

   localparam int LAP_DEPTH_DFLT = 8;

endpackage

// File: rtl/lap_regfile.sv
// -----------------------------------------------------------------------------
// lap_regfile
// DEPTH x 16-bit lap storage: one synchronous write port, one combinational
// read port. Storage has no reset; validity is tracked by the owner.
// Ports:
//   clk      in  : system clock (rising edge)
//   i_we     in  : write enable
//   i_waddr  in  : write slot index
//   i_wdata  in  : BCD time to store
//   i_raddr  in  : read slot index
//   o_rdata  out : contents of slot i_raddr (pre-write value in the write cycle)
// -----------------------------------------------------------------------------
module lap_regfile
   import stopwatch_pkg::*;
#(
   parameter int DEPTH = LAP_DEPTH_DFLT,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_waddr,
   input  bcd_time_t        i_wdata,
   input  logic [IDX_W-1:0] i_raddr,
   output bcd_time_t        o_rdata
);

   bcd_time_t r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lap_memory.sv
// -----------------------------------------------------------------------------
// lap_memory
// Lap (split) time recorder for the 00.00 stopwatch. Captures the live BCD
// time into a ring of DEPTH slots on each Lap press while running, and lets
// the user step through stored laps (oldest first) with View.
// Optional feature macro: LAP_OVERWRITE_EN
//   defined   : a lap taken while full overwrites the oldest slot
//   undefined : a lap taken while full is dropped
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   run_en             : stopwatch running flag (laps only captured when 1)
//   lap_p/view_p/clear_p : single-cycle button pulses
//   d3..d0             : live BCD digits
//   q3..q0             : registered digits to the display (live or recalled)
//   recall             : q shows a stored lap
//   view_idx           : lap number shown, 0 = oldest
//   lap_cnt            : number of valid slots (0..DEPTH)
//   full               : lap_cnt == DEPTH
// -----------------------------------------------------------------------------
module lap_memory
   import stopwatch_pkg::*;
#(
   parameter int DEPTH = LAP_DEPTH_DFLT,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run_en,
   input  logic             lap_p,
   input  logic             view_p,
   input  logic             clear_p,
   input  logic [3:0]       d3,
   input  logic [3:0]       d2,
   input  logic [3:0]       d1,
   input  logic [3:0]       d0,
   output logic [3:0]       q3,
   output logic [3:0]       q2,
   output logic [3:0]       q1,
   output logic [3:0]       q0,
   output logic             recall,
   output logic [IDX_W-1:0] view_idx,
   output logic [IDX_W:0]   lap_cnt,
   output logic             full
);

   localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
   localparam logic [IDX_W:0]   CNT_ZERO = '0;
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   lap_state_t       r_state;
   logic [IDX_W-1:0] r_wr_ptr;
   logic [IDX_W-1:0] r_view_idx;
   logic [IDX_W:0]   r_lap_cnt;
   bcd_time_t        r_q;
   logic             r_recall;
   logic             r_full;

   bcd_time_t        w_live;
   bcd_time_t        w_rd_data;
   logic             w_is_full;
   logic             w_cap;
   lap_state_t       w_state_nxt;
   logic [IDX_W-1:0] w_idx_nxt;
   logic [IDX_W-1:0] w_wr_nxt;
   logic [IDX_W:0]   w_cnt_nxt;
   logic [IDX_W-1:0] w_oldest_nxt;
   logic [IDX_W-1:0] w_rd_ptr;
   bcd_time_t        w_q_nxt;

   assign w_live    = '{d3: d3, d2: d2, d1: d1, d0: d0};
   assign w_is_full = (r_lap_cnt == CNT_FULL);

`ifdef LAP_OVERWRITE_EN
   assign w_cap = lap_p && run_en;
`else
   assign w_cap = lap_p && run_en && !w_is_full;
`endif

   // View stepping is judged against the lap count before any same-cycle capture.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_view_idx;
      if (view_p) begin
         case (r_state)
            LIVE: begin
               if (r_lap_cnt != CNT_ZERO) begin
                  w_state_nxt = RECALL;
                  w_idx_nxt   = '0;
               end
            end
            RECALL: begin
               if (({1'b0, r_view_idx} + CNT_ONE) < r_lap_cnt) begin
                  w_idx_nxt = r_view_idx + IDX_ONE;
               end else begin
                  w_state_nxt = LIVE;
                  w_idx_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = LIVE;
               w_idx_nxt   = '0;
            end
         endcase
      end
   end

   // An overwrite while full advances wr_ptr with lap_cnt pinned at DEPTH,
   // which moves the oldest pointer forward by one.
   assign w_wr_nxt     = w_cap ? (r_wr_ptr + IDX_ONE) : r_wr_ptr;
   assign w_cnt_nxt    = (w_cap && !w_is_full) ? (r_lap_cnt + CNT_ONE) : r_lap_cnt;
   assign w_oldest_nxt = w_wr_nxt - w_cnt_nxt[IDX_W-1:0];
   assign w_rd_ptr     = w_oldest_nxt + w_idx_nxt;

   lap_regfile #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_regfile (
      .clk     (clk),
      .i_we    (w_cap),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_live),
      .i_raddr (w_rd_ptr),
      .o_rdata (w_rd_data)
   );

   // Forward the live digits when the displayed slot is the one being written
   // this cycle, so q never shows the pre-overwrite contents.
   always_comb begin
      w_q_nxt = w_live;
      if (w_state_nxt == RECALL) begin
         if (w_cap && (w_rd_ptr == r_wr_ptr)) begin
            w_q_nxt = w_live;
         end else begin
            w_q_nxt = w_rd_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= LIVE;
         r_wr_ptr   <= '0;
         r_view_idx <= '0;
         r_lap_cnt  <= '0;
         r_recall   <= 1'b0;
         r_full     <= 1'b0;
         r_q        <= '0;
      end else if (clear_p) begin
         r_state    <= LIVE;
         r_wr_ptr   <= '0;
         r_view_idx <= '0;
         r_lap_cnt  <= '0;
         r_recall   <= 1'b0;
         r_full     <= 1'b0;
         r_q        <= w_live;
      end else begin
         r_state    <= w_state_nxt;
         r_wr_ptr   <= w_wr_nxt;
         r_view_idx <= w_idx_nxt;
         r_lap_cnt  <= w_cnt_nxt;
         r_recall   <= (w_state_nxt == RECALL);
         r_full     <= (w_cnt_nxt == CNT_FULL);
         r_q        <= w_q_nxt;
      end
   end

   assign q3       = r_q.d3;
   assign q2       = r_q.d2;
   assign q1       = r_q.d1;
   assign q0       = r_q.d0;
   assign recall   = r_recall;
   assign view_idx = r_view_idx;
   assign lap_cnt  = r_lap_cnt;
   assign full     = r_full;

endmodule

// File: tb/tb_lap_memory.sv
// -----------------------------------------------------------------------------
// tb_lap_memory
// Self-checking bench for lap_memory. A queue of stored laps (oldest first)
// plus a recall flag and index form the reference model; every cycle all
// outputs are compared against it. Honours LAP_OVERWRITE_EN like the design.
// -----------------------------------------------------------------------------
module tb_lap_memory;

   localparam int DEPTH = 8;
   localparam int IDX_W = $clog2(DEPTH);

   logic             clk;
   logic             rst_n;
   logic             run_en;
   logic             lap_p;
   logic             view_p;
   logic             clear_p;
   logic [3:0]       d3, d2, d1, d0;
   logic [3:0]       q3, q2, q1, q0;
   logic             recall;
   logic [IDX_W-1:0] view_idx;
   logic [IDX_W:0]   lap_cnt;
   logic             full;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [15:0] m_laps[$];
   logic        m_recall;
   int          m_idx;
   logic [15:0] m_q;

   lap_memory #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .run_en   (run_en),
      .lap_p    (lap_p),
      .view_p   (view_p),
      .clear_p  (clear_p),
      .d3       (d3),
      .d2       (d2),
      .d1       (d1),
      .d0       (d0),
      .q3       (q3),
      .q2       (q2),
      .q1       (q1),
      .q0       (q0),
      .recall   (recall),
      .view_idx (view_idx),
      .lap_cnt  (lap_cnt),
      .full     (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply the rules for one clock edge to the model.
   task automatic model_edge(input logic rn, input logic run, input logic lp,
                             input logic vp, input logic cp, input logic [15:0] dv);
      int n0;
      if (!rn) begin
         m_laps.delete();
         m_recall = 1'b0;
         m_idx    = 0;
         m_q      = 16'h0000;
      end else if (cp) begin
         m_laps.delete();
         m_recall = 1'b0;
         m_idx    = 0;
         m_q      = dv;
      end else begin
         n0 = m_laps.size();
         if (vp) begin
            if (!m_recall) begin
               if (n0 > 0) begin
                  m_recall = 1'b1;
                  m_idx    = 0;
               end
            end else if (m_idx < n0 - 1) begin
               m_idx++;
            end else begin
               m_recall = 1'b0;
               m_idx    = 0;
            end
         end
         if (lp && run) begin
            if (n0 < DEPTH) begin
               m_laps.push_back(dv);
            end else begin
`ifdef LAP_OVERWRITE_EN
               void'(m_laps.pop_front());
               m_laps.push_back(dv);
`endif
            end
         end
         m_q = m_recall ? m_laps[m_idx] : dv;
      end
   endtask

   task automatic step(input logic rn, input logic run, input logic lp,
                       input logic vp, input logic cp, input logic [15:0] dv);
      rst_n   = rn;
      run_en  = run;
      lap_p   = lp;
      view_p  = vp;
      clear_p = cp;
      {d3, d2, d1, d0} = dv;
      @(posedge clk);
      model_edge(rn, run, lp, vp, cp, dv);
      #1;
      chk("q",        {16'h0, q3, q2, q1, q0}, {16'h0, m_q});
      chk("recall",   32'(recall),   32'(m_recall));
      chk("view_idx", 32'(view_idx), 32'(m_idx));
      chk("lap_cnt",  32'(lap_cnt),  32'(m_laps.size()));
      chk("full",     32'(full),     32'(m_laps.size() == DEPTH));
   endtask

   function automatic logic [15:0] rand_bcd();
      return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
              4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
   endfunction

   initial begin
      m_recall = 1'b0;
      m_idx    = 0;
      m_q      = 16'h0;
      rst_n = 1'b1; run_en = 1'b0; lap_p = 1'b0; view_p = 1'b0; clear_p = 1'b0;
      {d3, d2, d1, d0} = 16'h0;
      @(negedge clk);

      // Reset
      step(0, 0, 0, 0, 0, 16'h5678);
      step(0, 0, 0, 0, 0, 16'h5678);
      chk("rst_q", {16'h0, q3, q2, q1, q0}, 32'h0);
      chk("rst_cnt", 32'(lap_cnt), 32'h0);

      // Lap while stopped
      step(1, 0, 1, 0, 0, 16'h1234);
      step(1, 0, 0, 1, 0, 16'h1234);
      chk("stopped_recall", 32'(recall), 32'h0);

      // Basic capture and browse
      step(1, 1, 1, 0, 0, 16'h0123);
      step(1, 1, 0, 0, 0, 16'h0200);
      step(1, 1, 1, 0, 0, 16'h0456);
      step(1, 1, 0, 0, 0, 16'h0500);
      step(1, 1, 1, 0, 0, 16'h0789);
      step(1, 1, 0, 1, 0, 16'h1000);
      chk("browse0", {16'h0, q3, q2, q1, q0}, 32'h0123);
      step(1, 1, 0, 1, 0, 16'h1001);
      chk("browse1", {16'h0, q3, q2, q1, q0}, 32'h0456);
      step(1, 1, 0, 1, 0, 16'h1002);
      chk("browse2", {16'h0, q3, q2, q1, q0}, 32'h0789);
      step(1, 1, 0, 1, 0, 16'h1003);
      chk("browse_live", {16'h0, q3, q2, q1, q0}, 32'h1003);
      step(1, 1, 0, 0, 0, 16'h1004);

      // Full: nine laps
      step(1, 1, 0, 0, 1, 16'h0000);
      for (int i = 1; i <= 9; i++) begin
         step(1, 1, 1, 0, 0, 16'(i));
      end
      chk("full_flag", 32'(full), 32'h1);
      chk("full_cnt", 32'(lap_cnt), 32'(DEPTH));
      step(1, 1, 0, 1, 0, 16'h2000);
`ifdef LAP_OVERWRITE_EN
      chk("full_oldest", {16'h0, q3, q2, q1, q0}, 32'h0002);
`else
      chk("full_oldest", {16'h0, q3, q2, q1, q0}, 32'h0001);
`endif
      for (int i = 0; i < DEPTH; i++) begin
         step(1, 1, 0, 1, 0, 16'h2001);
      end
      // Overwrite (or drop) while recalling
      step(1, 1, 0, 1, 0, 16'h2002);
      step(1, 1, 0, 1, 0, 16'h2003);
      step(1, 1, 1, 0, 0, 16'h0042);
      step(1, 1, 1, 1, 0, 16'h0043);

      // Simultaneous clear, lap, view in RECALL idx1
      step(1, 1, 0, 0, 1, 16'h0000);
      step(1, 1, 1, 0, 0, 16'h0311);
      step(1, 1, 1, 0, 0, 16'h0322);
      step(1, 1, 0, 1, 0, 16'h0333);
      step(1, 1, 0, 1, 0, 16'h0344);
      chk("sim_idx1", 32'(view_idx), 32'h1);
      step(1, 1, 1, 1, 1, 16'h0355);
      chk("sim_cnt", 32'(lap_cnt), 32'h0);
      chk("sim_recall", 32'(recall), 32'h0);

      // Lap and view together: view sees the pre-capture count
      step(1, 1, 1, 1, 0, 16'h0366);
      step(1, 1, 1, 0, 0, 16'h0377);
      step(1, 1, 0, 1, 0, 16'h0388);
      step(1, 1, 1, 1, 0, 16'h0399);
      step(1, 1, 0, 1, 0, 16'h0400);

      // Reset mid-recall
      step(1, 1, 0, 1, 0, 16'h0410);
      step(0, 1, 0, 0, 0, 16'h0420);
      chk("rst_mid_q", {16'h0, q3, q2, q1, q0}, 32'h0);
      step(1, 1, 0, 1, 0, 16'h0430);
      chk("rst_mid_view", 32'(recall), 32'h0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) != 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 59) == 0),
              rand_bcd());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lap_memory.md
# lap_memory

Lap (split) time recorder placed directly downstream of the BCD counter chain in the 00.00 stopwatch. It captures the live four-digit BCD time into a small register file on each Lap press, and lets the user step through stored laps with a View button. It outputs the four digits, live or recalled, that feed the 7-segment decoders. All button inputs are single-cycle pulses already produced by the synchronizer/debouncer path in the 100 MHz domain.

## Interface
- `DEPTH`, 8: number of lap slots; power of two, 2..16.
- `IDX_W`, $clog2(DEPTH): width of slot index.
- `clk`  in  1: 100 MHz system clock; all logic is on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `run_en`  in  1: stopwatch running flag from the run-control flip-flop.
- `lap_p`  in  1: one-cycle Lap pulse.
- `view_p`  in  1: one-cycle View/step pulse.
- `clear_p`  in  1: one-cycle clear pulse, tied to the debounced Reset pulse.
- `d3,d2,d1,d0`  in  4 each: live BCD digits (10 s, 1 s, 0.1 s, 0.01 s).
- `q3,q2,q1,q0`  out  4 each: digits to the display decoders.
- `recall`  out  1: 1 when the q outputs show a stored lap.
- `view_idx`  out  IDX_W: lap number being shown, 0 = oldest stored lap.
- `lap_cnt`  out  IDX_W+1: number of valid slots, 0..DEPTH.
- `full`  out  1: `lap_cnt == DEPTH`.

## Operation
- States:
  - LIVE: q follows d.
  - RECALL: q follows slot[rd_ptr].
- Capture:
  - `lap_p && run_en` writes {d3,d2,d1,d0} to slot[wr_ptr], increments wr_ptr modulo DEPTH, and increments lap_cnt.
  - `lap_p` with `run_en=0` is ignored.
- Full without the macro: `lap_p` is ignored and the slots are unchanged.
- LIVE → RECALL on `view_p` when lap_cnt > 0. Sets view_idx=0 and points at the oldest slot.
- `view_p` with lap_cnt == 0 is ignored; the block stays in LIVE.
- RECALL, `view_p`:
  - If view_idx < lap_cnt−1: view_idx increments.
  - Otherwise: return to LIVE with view_idx=0.
- Capture is allowed in RECALL. The stored data and lap_cnt update, and the displayed slot does not change.
- `clear_p` in any state: lap_cnt=0, wr_ptr=0, view_idx=0, state LIVE. Slot contents need not be cleared.
- Priority within one cycle:
  - `clear_p` overrides lap_p and view_p.
  - When lap_p and view_p coincide, both act. view_p is evaluated against lap_cnt as it was before the capture.
- The oldest slot is `(wr_ptr − lap_cnt) mod DEPTH`. rd_ptr is `(oldest + view_idx) mod DEPTH`.
- Digits are stored verbatim; no BCD arithmetic is done.

## Timing
- Reset (rst_n=0 at a clock edge) sets:
  - state LIVE, lap_cnt=0, wr_ptr=0, view_idx=0
  - recall=0, full=0, q=0
- q, recall, view_idx, lap_cnt and full are registered outputs.
- q lags d by 1 cycle in LIVE.
- A capture on edge N is visible in lap_cnt and full after edge N.
- A view_p on edge N changes recall, view_idx and q after edge N. q shows the stored data from that same edge.
- Reset or clear mid-recall returns the block to LIVE on the next edge; nothing is retained.

## Configuration
- `LAP_OVERWRITE_EN` defined:
  - When full, `lap_p && run_en` overwrites the oldest slot.
  - wr_ptr advances, lap_cnt stays at DEPTH, and the oldest index moves forward by one.
  - If in RECALL, view_idx is kept; the displayed slot is re-resolved through the new oldest pointer.
- `LAP_OVERWRITE_EN` undefined: laps pressed while full are dropped, as described under Operation.

## Structure
- Shared package `stopwatch_pkg` holds:
  - `bcd_time_t`, a packed struct {d3,d2,d1,d0}.
  - The `lap_state_t` enum {LIVE, RECALL}.
  - `LAP_DEPTH_DFLT` = 8.
- Sub-module `lap_regfile`: DEPTH × 16-bit storage with one synchronous write port and one combinational read port. No reset on storage.

## Test plan
- Lap while stopped:
  - Stimulus: reset, run_en=0, d=12.34, lap_p.
  - Response: lap_cnt=0; view_p → recall stays 0.
- Basic capture and browse:
  - Stimulus: run_en=1; laps at 01.23, 04.56, 07.89; then view_p ×4.
  - Response: q=01.23/idx0, 04.56/idx1, 07.89/idx2, then LIVE with q=d on the next cycle.
- Full, macro undefined:
  - Stimulus: 9 laps at 00.01..00.09.
  - Response: full=1, lap_cnt=8; browsing shows 00.01..00.08.
- Full, macro defined:
  - Stimulus: same 9 laps.
  - Response: lap_cnt=8; browsing shows 00.02..00.09.
- Simultaneous events:
  - Stimulus: in RECALL idx1, assert clear_p, lap_p and view_p together.
  - Response: LIVE, lap_cnt=0, recall=0.
- Reset mid-recall:
  - Stimulus: rst_n=0 for 1 cycle while in RECALL.
  - Response: all outputs 0; a following view_p is ignored because lap_cnt=0.
